// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a data port.
// Grants alternate on conflict; reads that never complete are answered with zero and flagged.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [DATA_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  output logic                  inst_ready,
  input  logic                  data_rd_req,
  input  logic                  data_wr_req,
  input  logic [3:0]            data_ctrl,
  input  logic [DATA_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_ready,
  output logic                  mem_we,
  output logic                  mem_rd,
  output logic [3:0]            mem_ctrl,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_dout_ready,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  state_t                state;
  logic                  last_grant;  // also identifies the current winner after IDLE
  logic                  op_write;
  logic [DATA_WIDTH-1:0] rdata;
  logic [CW-1:0]         wait_cnt;

  logic data_req;
  logic pick_data;

  always_comb begin
    data_req  = data_rd_req | data_wr_req;
    pick_data = data_req & (~inst_req | (last_grant == GRANT_INST));
  end

  assign inst_rdata = rdata;
  assign data_rdata = rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GRANT_INST;
      op_write    <= 1'b0;
      rdata       <= '0;
      wait_cnt    <= '0;
      mem_we      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_ctrl    <= 4'b0000;
      mem_addr    <= '0;
      mem_di      <= '0;
      inst_ready  <= 1'b0;
      data_ready  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      mem_rd     <= 1'b0;
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_req || data_req) begin
            last_grant <= pick_data;
            state      <= ISSUE;
            if (pick_data) begin
              // A simultaneous read+write request is resolved as a write.
              op_write <= data_wr_req;
              mem_we   <= data_wr_req;
              mem_rd   <= ~data_wr_req;
              mem_addr <= data_addr;
              mem_ctrl <= data_ctrl;
              mem_di   <= data_wdata;
            end else begin
              op_write <= 1'b0;
              mem_rd   <= 1'b1;
              mem_addr <= inst_addr;
              mem_ctrl <= 4'b1111;
              mem_di   <= '0;
            end
          end
        end
        ISSUE: begin
          if (op_write || mem_dout_ready) begin
            if (!op_write) rdata <= mem_dout;
            state      <= RESP;
            inst_ready <= (last_grant == GRANT_INST);
            data_ready <= (last_grant == GRANT_DATA);
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_dout_ready) begin
            rdata      <= mem_dout;
            state      <= RESP;
            inst_ready <= (last_grant == GRANT_INST);
            data_ready <= (last_grant == GRANT_DATA);
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            rdata       <= '0;
            state       <= RESP;
            inst_ready  <= (last_grant == GRANT_INST);
            data_ready  <= (last_grant == GRANT_DATA);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions against a word memory
// model with selectable response behaviour, plus conflict, timeout and reset sequences.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_rd_req;
  logic        data_wr_req;
  logic [3:0]  data_ctrl;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        mem_we;
  logic        mem_rd;
  logic [3:0]  mem_ctrl;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_dout;
  logic        mem_dout_ready;
  logic        timeout_err;

  mem_port_arbiter #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_rd_req(data_rd_req), .data_wr_req(data_wr_req), .data_ctrl(data_ctrl),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_dout(mem_dout), .mem_dout_ready(mem_dout_ready), .timeout_err(timeout_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: 0 = same-cycle response, 1 = next-cycle, 2 = never, 3 = manual
  int          mode;
  logic [31:0] mem [256];
  logic        rdy_r;
  logic [31:0] dout_r;
  logic        manual_ready;
  logic [31:0] manual_dout;

  always @(posedge clk) begin
    if (rst) rdy_r <= 1'b0;
    else     rdy_r <= mem_rd;
    dout_r <= mem[mem_addr[7:0]];
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_ctrl[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_di[8*b +: 8];
  end

  always_comb begin
    mem_dout_ready = 1'b0;
    mem_dout       = '0;
    case (mode)
      0: begin mem_dout_ready = mem_rd; mem_dout = mem[mem_addr[7:0]]; end
      1: begin mem_dout_ready = rdy_r;  mem_dout = dout_r; end
      3: begin mem_dout_ready = manual_ready; mem_dout = manual_dout; end
      default: ;
    endcase
  end

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_inst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  ctrl;
    logic [31:0] wdata;
    int          mode;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } txn_t;

  function automatic txn_t mk(input logic is_inst, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [3:0] ctrl,
                              input logic [31:0] wdata, input int m,
                              input logic [31:0] exp_rdata, input int exp_lat);
    txn_t t;
    t.is_inst = is_inst; t.rd = rd; t.wr = wr; t.addr = addr; t.ctrl = ctrl;
    t.wdata = wdata; t.mode = m; t.exp_rdata = exp_rdata; t.exp_lat = exp_lat;
    return t;
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    inst_req = 1'b0; data_rd_req = 1'b0; data_wr_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
  task automatic run_txn(input string tag, input txn_t t);
    int lat = 0;
    int strobes = 0;
    int strobe_cyc = -1;
    int wrong = 0;
    logic got = 1'b0;
    logic saw_we = 1'b0;
    logic [31:0] got_data = '0;
    logic [31:0] s_addr = '0;
    logic [31:0] s_di = '0;
    logic [3:0]  s_ctrl = '0;
    mode = t.mode;
    if (t.is_inst) begin
      inst_req = 1'b1; inst_addr = t.addr;
    end else begin
      data_rd_req = t.rd; data_wr_req = t.wr;
      data_addr = t.addr; data_ctrl = t.ctrl; data_wdata = t.wdata;
    end
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (mem_rd || mem_we) begin
        strobes += int'(mem_rd) + int'(mem_we);
        strobe_cyc = lat; saw_we = mem_we;
        s_addr = mem_addr; s_di = mem_di; s_ctrl = mem_ctrl;
      end
      if (t.is_inst) begin
        wrong += int'(data_ready);
        if (inst_ready) begin got = 1'b1; got_data = inst_rdata; end
      end else begin
        wrong += int'(inst_ready);
        if (data_ready) begin got = 1'b1; got_data = data_rdata; end
      end
    end
    inst_req = 1'b0; data_rd_req = 1'b0; data_wr_req = 1'b0;
    check({tag, "_ready_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(t.exp_lat));
    check({tag, "_strobes"}, 32'(strobes), 32'd1);
    check({tag, "_strobe_cycle"}, 32'(strobe_cyc), 32'd1);
    check({tag, "_strobe_is_we"}, 32'(saw_we), 32'(t.wr));
    check({tag, "_mem_addr"}, s_addr, t.addr);
    check({tag, "_mem_ctrl"}, 32'(s_ctrl), t.is_inst ? 32'hF : 32'(t.ctrl));
    check({tag, "_other_ready"}, 32'(wrong), 32'd0);
    if (t.wr) check({tag, "_mem_di"}, s_di, t.wdata);
    else      check({tag, "_rdata"}, got_data, t.exp_rdata);
    @(posedge clk);
    @(negedge clk);
  endtask

  txn_t vec [11];

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_rd_req = 1'b0; data_wr_req = 1'b0; data_ctrl = '0; data_addr = '0; data_wdata = '0;
    mode = 1; manual_ready = 1'b0; manual_dout = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 32'h00500113;

    vec[0]  = mk(1, 1, 0, 32'd4,   4'hF, 32'h0,        1, 32'h00500113, 3);
    vec[1]  = mk(0, 0, 1, 32'd100, 4'hF, 32'd25,       1, 32'h0,        2);
    vec[2]  = mk(0, 1, 0, 32'd100, 4'hF, 32'h0,        1, 32'd25,       3);
    vec[3]  = mk(0, 0, 1, 32'd8,   4'h1, 32'hAABBCCDD, 1, 32'h0,        2);
    vec[4]  = mk(0, 1, 0, 32'd8,   4'hF, 32'h0,        1, 32'h000000DD, 3);
    vec[5]  = mk(1, 1, 0, 32'd100, 4'hF, 32'h0,        0, 32'd25,       2);
    vec[6]  = mk(0, 1, 0, 32'd4,   4'hF, 32'h0,        0, 32'h00500113, 2);
    vec[7]  = mk(0, 0, 1, 32'd12,  4'h6, 32'h11223344, 0, 32'h0,        2);
    vec[8]  = mk(0, 1, 0, 32'd12,  4'hF, 32'h0,        1, 32'h00223300, 3);
    vec[9]  = mk(0, 1, 1, 32'd16,  4'hF, 32'h5A5A5A5A, 1, 32'h0,        2);
    vec[10] = mk(0, 1, 0, 32'd16,  4'hF, 32'h0,        0, 32'h5A5A5A5A, 2);

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_inst_ready", 32'(inst_ready), 32'd0);
    check("rst_data_ready", 32'(data_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_ctrl", 32'(mem_ctrl), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_di", mem_di, 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_rdata", data_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_txn($sformatf("v%0d", i), vec[i]);

    // conflict: both ports held high, data wins first, then strict alternation
    do_reset();
    mode = 1;
    for (int k = 0; k < 8; k++)
      exp_q.push_back((k % 2 == 0) ? {1'b1, 32'd25} : {1'b0, 32'h00500113});
    inst_req = 1'b1; inst_addr = 32'd4;
    data_rd_req = 1'b1; data_addr = 32'd100; data_ctrl = 4'hF;
    begin
      int cyc = 0;
      int seen = 0;
      while (exp_q.size() > 0 && cyc < 200) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (inst_ready && data_ready) check("cf_both_ready", 32'd1, 32'd0);
        if (inst_ready || data_ready) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check($sformatf("cf%0d_is_data", seen), 32'(data_ready), 32'(e[32]));
          check($sformatf("cf%0d_rdata", seen), data_ready ? data_rdata : inst_rdata, e[31:0]);
          seen++;
        end
      end
      inst_req = 1'b0; data_rd_req = 1'b0;
      check("cf_count", 32'(seen), 32'd8);
      exp_q.delete();
    end
    @(posedge clk);
    @(negedge clk);

    // timeout: memory never answers
    check("to_before", 32'(timeout_err), 32'd0);
    run_txn("to", mk(0, 1, 0, 32'd4, 4'hF, 32'h0, 2, 32'h0, 18));
    check("to_set", 32'(timeout_err), 32'd1);
    run_txn("to_after", mk(1, 1, 0, 32'd4, 4'hF, 32'h0, 1, 32'h00500113, 3));
    check("to_sticky", 32'(timeout_err), 32'd1);

    // reset while waiting, then a late response must be ignored
    mode = 3;
    data_rd_req = 1'b1; data_addr = 32'd4; data_ctrl = 4'hF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; data_rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    manual_ready = 1'b1; manual_dout = 32'hDEADBEEF;
    begin
      int stray = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        @(negedge clk);
        stray += int'(inst_ready) + int'(data_ready) + int'(mem_rd) + int'(mem_we);
      end
      check("rw_no_pulse", 32'(stray), 32'd0);
    end
    check("rw_mem_addr", mem_addr, 32'd0);
    check("rw_mem_di", mem_di, 32'd0);
    check("rw_mem_ctrl", 32'(mem_ctrl), 32'd0);
    check("rw_rdata", data_rdata, 32'd0);
    check("rw_timeout_clr", 32'(timeout_err), 32'd0);
    manual_ready = 1'b0;
    run_txn("rw_next", mk(0, 1, 0, 32'd100, 4'hF, 32'h0, 1, 32'd25, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
